// File: rtl/dcounter_pkg.sv
// Shared definitions for the dcounter bank: boundary-mode encodings and
// a helper that yields the all-ones value for a given counter width.
package dcounter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP   = 2'd0,
      MODE_SAT    = 2'd1,
      MODE_RELOAD = 2'd2
   } mode_e;

   // Widest counter the all-ones helper can describe.
   localparam int unsigned MAX_WIDTH = 64;

   // All-ones value for a counter of the given width, right-aligned.
   function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = {MAX_WIDTH{1'b0}};
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/dcounter_cell.sv
// One counter channel: count, reload and terminal-count registers.
// Priority at each edge is clr > load > en. A boundary event (en with the
// count at the limit for the current direction) is resolved by MODE.
module dcounter_cell
   import dcounter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = 0
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));
   localparam logic [1:0]       MODE_BITS = MODE[1:0];
   localparam mode_e            MODE_SEL  = mode_e'(MODE_BITS);

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] reload_r;
   logic             tc_r;

   logic             at_boundary_s;
   logic [WIDTH-1:0] boundary_val_s;
   logic [WIDTH-1:0] count_nxt_s;
   logic [WIDTH-1:0] reload_nxt_s;
   logic             tc_nxt_s;

   // Detect that the next enabled step would leave the counter's range.
   always_comb begin
      at_boundary_s = 1'b0;
      if (up) begin
         at_boundary_s = (count_r == ALL_ONES);
      end else begin
         at_boundary_s = (count_r == ZERO);
      end
   end

   // Value taken on a boundary event, chosen by the bank-wide mode.
   always_comb begin
      boundary_val_s = count_r;
      case (MODE_SEL)
         MODE_WRAP: begin
            if (up) begin
               boundary_val_s = ZERO;
            end else begin
               boundary_val_s = ALL_ONES;
            end
         end
         MODE_SAT: begin
            boundary_val_s = count_r;
         end
         MODE_RELOAD: begin
            if (up) begin
               boundary_val_s = ZERO;
            end else begin
               boundary_val_s = reload_r;
            end
         end
         default: begin
            if (up) begin
               boundary_val_s = ZERO;
            end else begin
               boundary_val_s = ALL_ONES;
            end
         end
      endcase
   end

   // Next-state selection with clr > load > en priority.
   always_comb begin
      count_nxt_s  = count_r;
      reload_nxt_s = reload_r;
      tc_nxt_s     = 1'b0;
      if (clr) begin
         count_nxt_s = ZERO;
      end else if (load) begin
         count_nxt_s  = load_val;
         reload_nxt_s = load_val;
      end else if (en) begin
         if (at_boundary_s) begin
            count_nxt_s = boundary_val_s;
            tc_nxt_s    = 1'b1;
         end else if (up) begin
            count_nxt_s = count_r + ONE;
         end else begin
            count_nxt_s = count_r - ONE;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // State registers; asynchronous reset clears everything including tc.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= ZERO;
         reload_r <= ZERO;
         tc_r     <= 1'b0;
      end else begin
         count_r  <= count_nxt_s;
         reload_r <= reload_nxt_s;
         tc_r     <= tc_nxt_s;
      end
   end

   assign count = count_r;
   assign tc    = tc_r;

endmodule

// File: rtl/dcounter_bank.sv
// Bank of CHANNELS independent WIDTH-bit counters sharing one clock and
// one boundary mode. Flat buses pack channel i at [i*WIDTH +: WIDTH].
module dcounter_bank
   import dcounter_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MODE     = 0
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       up,
   input  logic [CHANNELS-1:0]       clr,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   output logic [CHANNELS*WIDTH-1:0] d_out,
   output logic [CHANNELS-1:0]       zero,
   output logic [CHANNELS-1:0]       tc
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      dcounter_cell #(
         .WIDTH (WIDTH),
         .MODE  (MODE)
      ) u_cell (
         .clock    (clock),
         .rst_n    (rst_n),
         .en       (en[i]),
         .up       (up[i]),
         .clr      (clr[i]),
         .load     (load[i]),
         .load_val (load_val[i*WIDTH +: WIDTH]),
         .count    (d_out[i*WIDTH +: WIDTH]),
         .tc       (tc[i])
      );

      // zero follows the registered count without an extra cycle.
      assign zero[i] = (d_out[i*WIDTH +: WIDTH] == ZERO);
   end

endmodule

// File: tb/tb_dcounter_bank.sv
// Directed bench: three banks (wrap, saturate, auto-reload) share the
// same stimulus; each scenario checks the bank whose mode it targets.
module tb_dcounter_bank;

   logic        clock;
   logic        rst_n;
   logic [3:0]  en, up, clr, load;
   logic [63:0] load_val;
   logic [63:0] d_out_w, d_out_s, d_out_r;
   logic [3:0]  zero_w, zero_s, zero_r;
   logic [3:0]  tc_w, tc_s, tc_r;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] rel_cnt [8] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
   logic        rel_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   dcounter_bank #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_wrap (
      .clock(clock), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .d_out(d_out_w), .zero(zero_w), .tc(tc_w));

   dcounter_bank #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_sat (
      .clock(clock), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .d_out(d_out_s), .zero(zero_s), .tc(tc_s));

   dcounter_bank #(.WIDTH(16), .CHANNELS(4), .MODE(2)) u_rel (
      .clock(clock), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .d_out(d_out_r), .zero(zero_r), .tc(tc_r));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] ch(input logic [63:0] bus, input int i);
      return bus[i*16 +: 16];
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 4'hF; up = 4'h0; clr = 4'h0; load = 4'h0;
      load_val = 64'h0;

      // Reset held with en asserted: nothing counts.
      step();
      step();
      check_val("rst_dout_w", d_out_w, 64'h0);
      check_val("rst_tc_w", {60'h0, tc_w}, 64'h0);
      check_val("rst_dout_r", d_out_r, 64'h0);
      rst_n = 1'b1;
      check_val("rel_pre_edge", {48'h0, ch(d_out_w, 0)}, 64'h0);
      step();
      check_val("first_cnt_w0", {48'h0, ch(d_out_w, 0)}, 64'hFFFF);
      check_val("first_tc_w0", {63'h0, tc_w[0]}, 64'h1);
      check_val("first_cnt_s0", {48'h0, ch(d_out_s, 0)}, 64'h0);
      check_val("first_tc_s0", {63'h0, tc_s[0]}, 64'h1);
      check_val("first_cnt_r0", {48'h0, ch(d_out_r, 0)}, 64'h0);
      en = 4'h0;
      step();
      check_val("idle_tc_w", {60'h0, tc_w}, 64'h0);

      // Wrap on ch1.
      load = 4'b0010; load_val = 64'h0000_0000_0002_0000;
      step();
      check_val("wrap_load", {48'h0, ch(d_out_w, 1)}, 64'h2);
      load = 4'h0; en = 4'b0010; up = 4'h0;
      step();
      check_val("wrap_c1", {48'h0, ch(d_out_w, 1)}, 64'h1);
      check_val("wrap_z1", {63'h0, zero_w[1]}, 64'h0);
      check_val("wrap_t1", {63'h0, tc_w[1]}, 64'h0);
      step();
      check_val("wrap_c0", {48'h0, ch(d_out_w, 1)}, 64'h0);
      check_val("wrap_z0", {63'h0, zero_w[1]}, 64'h1);
      check_val("wrap_t0", {63'h0, tc_w[1]}, 64'h0);
      step();
      check_val("wrap_cF", {48'h0, ch(d_out_w, 1)}, 64'hFFFF);
      check_val("wrap_zF", {63'h0, zero_w[1]}, 64'h0);
      check_val("wrap_tF", {63'h0, tc_w[1]}, 64'h1);
      check_val("wrap_rel_ch1", {48'h0, ch(d_out_r, 1)}, 64'h2);
      check_val("wrap_sat_ch1", {48'h0, ch(d_out_s, 1)}, 64'h0);
      en = 4'h0;
      step();
      check_val("wrap_tc_end", {63'h0, tc_w[1]}, 64'h0);

      // Saturate on ch2, counting up.
      load = 4'b0100; load_val = 64'h0000_FFFE_0000_0000;
      step();
      check_val("sat_load", {48'h0, ch(d_out_s, 2)}, 64'hFFFE);
      load = 4'h0; en = 4'b0100; up = 4'b0100;
      step();
      check_val("sat_c1", {48'h0, ch(d_out_s, 2)}, 64'hFFFF);
      check_val("sat_t1", {63'h0, tc_s[2]}, 64'h0);
      for (int k = 2; k <= 4; k++) begin
         step();
         check_val($sformatf("sat_c%0d", k), {48'h0, ch(d_out_s, 2)}, 64'hFFFF);
         check_val($sformatf("sat_t%0d", k), {63'h0, tc_s[2]}, 64'h1);
         if (k == 2) check_val("sat_wrap_ch2", {48'h0, ch(d_out_w, 2)}, 64'h0);
      end
      en = 4'h0; up = 4'h0;
      step();
      check_val("sat_tc_end", {63'h0, tc_s[2]}, 64'h0);

      // Auto-reload on ch0, counting down.
      load = 4'b0001; load_val = 64'h0000_0000_0000_0003;
      step();
      check_val("rel_load", {48'h0, ch(d_out_r, 0)}, 64'h3);
      load = 4'h0; en = 4'b0001; up = 4'h0;
      for (int k = 0; k < 8; k++) begin
         step();
         check_val($sformatf("rel_c%0d", k), {48'h0, ch(d_out_r, 0)}, {48'h0, rel_cnt[k]});
         check_val($sformatf("rel_t%0d", k), {63'h0, tc_r[0]}, {63'h0, rel_tc[k]});
      end
      step();
      check_val("rel_pre_clr", {48'h0, ch(d_out_r, 0)}, 64'h2);
      clr = 4'b0001;
      step();
      check_val("rel_clr", {48'h0, ch(d_out_r, 0)}, 64'h0);
      check_val("rel_clr_tc", {63'h0, tc_r[0]}, 64'h0);
      clr = 4'h0;
      step();
      check_val("rel_after_clr", {48'h0, ch(d_out_r, 0)}, 64'h3);
      check_val("rel_after_clr_tc", {63'h0, tc_r[0]}, 64'h1);
      en = 4'h0;

      // Priority clr > load > en on ch3; other channels stay put.
      clr = 4'hF;
      step();
      check_val("pri_allclr", d_out_w, 64'h0);
      clr = 4'b1000; load = 4'b1000; en = 4'b1000; up = 4'h0;
      load_val = {4{16'h1234}};
      step();
      check_val("pri_clr_wins", {48'h0, ch(d_out_w, 3)}, 64'h0);
      check_val("pri_others0", {16'h0, d_out_w[47:0]}, 64'h0);
      clr = 4'h0;
      step();
      check_val("pri_load_wins", {48'h0, ch(d_out_w, 3)}, 64'h1234);
      check_val("pri_others1", {16'h0, d_out_w[47:0]}, 64'h0);
      load = 4'h0;
      step();
      check_val("pri_count", {48'h0, ch(d_out_w, 3)}, 64'h1233);
      en = 4'h0;

      // Async reset while a tc pulse is in flight.
      load = 4'hF; load_val = {4{16'h0001}};
      step();
      load = 4'h0; en = 4'b0001; up = 4'h0;
      step();
      step();
      check_val("ar_pre_tc", {63'h0, tc_r[0]}, 64'h1);
      check_val("ar_pre_cnt", {48'h0, ch(d_out_r, 0)}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check_val("ar_dout_r", d_out_r, 64'h0);
      check_val("ar_tc_r", {60'h0, tc_r}, 64'h0);
      check_val("ar_dout_w", d_out_w, 64'h0);
      rst_n = 1'b1;
      step();
      check_val("ar_reload_cleared", {48'h0, ch(d_out_r, 0)}, 64'h0);
      check_val("ar_reload_tc", {63'h0, tc_r[0]}, 64'h1);
      check_val("ar_wrap_after", {48'h0, ch(d_out_w, 0)}, 64'hFFFF);
      en = 4'h0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dcounter_bank.md
Name: dcounter_bank

Overview:
- Parametrised successor to the team's single 16-bit decrementing counter: a bank of CHANNELS independent WIDTH-bit counters.
- Each channel adds direction control, parallel load, synchronous clear and a configurable boundary mode (wrap, saturate, or auto-reload from the load value).
- Each channel also has a registered terminal-count pulse.
- Used as a timer/event-counter resource for the benchmark designs; all channels run in one clock domain.

Parameters:
- WIDTH, 16, bits per channel counter (>=2).
- CHANNELS, 4, number of independent channels (>=1).
- MODE, 0, boundary behaviour shared by all channels: 0 = wrap, 1 = saturate, 2 = auto-reload.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel count enable.
- up  in  CHANNELS  per-channel direction: 1 = increment, 0 = decrement.
- clr  in  CHANNELS  per-channel synchronous clear.
- load  in  CHANNELS  per-channel synchronous parallel load.
- load_val  in  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- d_out  out  CHANNELS*WIDTH  counter values, same packing as load_val.
- zero  out  CHANNELS  combinational, high when channel count == 0.
- tc  out  CHANNELS  registered one-cycle terminal-count pulse.

Behaviour:
- Interface (already decided): one clock, named clock. Reset rst_n is asynchronous and active-low. On rst_n=0, all counters go to 0, all tc go to 0, and all reload registers go to 0, immediately and independent of clock. Release is sampled on the next rising edge; no count occurs on the edge where rst_n is still low.
- Per-channel priority at each rising edge: clr > load > en. Channels are fully independent; simultaneous events on different channels do not interact.
- clr=1: count <= 0; tc <= 0.
- load=1 (clr=0): count <= load_val slice; reload register <= load_val slice; tc <= 0.
- en=1 (clr=0, load=0): count moves by 1 in the direction given by up. Arithmetic is modulo 2^WIDTH unless a boundary case applies.
- en=0 (clr=0, load=0): count holds; tc <= 0.
- Boundary event: en=1, clr=0, load=0, and either (up=0, count==0) or (up=1, count==2^WIDTH-1). The boundary result depends on MODE:
  - MODE 0 (wrap): count wraps (0 -> all-ones, all-ones -> 0).
  - MODE 1 (saturate): count holds at the boundary value.
  - MODE 2 (auto-reload): when down-counting, count <= reload register. When up-counting, count <= 0.
- tc: tc <= 1 on every edge where a boundary event occurs, otherwise 0. tc is therefore high in the cycle after the event edge, aligned with the new count.
  - In saturate mode, tc re-pulses on every enabled cycle spent at the boundary.
- Latency: d_out reflects an input one cycle after the sampling edge; zero follows d_out combinationally.
- Reload register is written only by load. clr does not change it.
- Reset mid-count: asynchronous reset overrides everything, including a tc pulse in flight.

Decomposition:
- Package dcounter_pkg holds the MODE encodings (MODE_WRAP=0, MODE_SAT=1, MODE_RELOAD=2) and a helper constant for the all-ones value derived from WIDTH.
- One sub-module, dcounter_cell: a single WIDTH-bit channel holding count, reload and tc registers. The top level generates CHANNELS instances and packs/unpacks the flat buses.

Test Plan:
- Reset/release: hold rst_n=0 with en=all-ones, then release -> d_out=0 and tc=0. First count appears one edge after release; ch0 down in MODE 0 reads 16'hFFFF.
- Wrap, MODE 0, WIDTH=16: load ch1=16'h0002, then en with up=0 for 3 cycles -> 2, 1, 0, 16'hFFFF. tc[1] high only with 16'hFFFF. zero[1] high only at 0.
- Saturate, MODE 1: load ch2=16'hFFFE, then up=1 for 4 cycles -> FFFF, FFFF, FFFF, FFFF. tc[2] high on the last three cycles.
- Auto-reload, MODE 2: load ch0=3, then down for 8 cycles -> 2, 1, 0, 3, 2, 1, 0, 3. tc[0] pulses with each 3 after 0. A clr mid-run gives 0, and the next underflow reloads 3.
- Priority: in one cycle assert clr, load (val 16'h1234) and en on ch3 -> count=0. Next cycle load+en -> count=16'h1234. Other channels are unaffected throughout.
- Async reset mid-operation: drop rst_n between edges while counting -> d_out=0 and tc=0 immediately (before the next edge). Reload registers also read back 0 after the next down underflow in MODE 2.
